// File: rtl/phy_stream_checker.sv
// Loopback stream checker: buffers golden symbols, compares them in order against DUT output,
// keeps saturating match/error/underflow statistics and declares end-of-run after an idle timeout.
module phy_stream_checker #(
  parameter int W       = 1,
  parameter int DEPTH   = 64,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 200,
  parameter int SKIP    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [W-1:0]     golden_data,
  input  logic             golden_valid,
  output logic             golden_ready,
  input  logic [W-1:0]     dut_data,
  input  logic             dut_valid,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] underflow_count,
  output logic             overflow,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid,
  output logic             done,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [SW-1:0] SKIP_V = SW'(SKIP);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DONE} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  state_t         state, state_nxt;
  logic [W-1:0]   mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic [IW-1:0]  idle_cnt;
  logic [SW-1:0]  skip_cnt;
  logic           clr, live, full, empty, push, pop, under, in_skip, match;

  assign clr   = rst || clear;
  assign live  = (state != ST_DONE);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign golden_ready = !full && live;
  assign push    = golden_valid && golden_ready;
  assign pop     = dut_valid && !empty && live;
  assign under   = dut_valid && empty && live;
  assign in_skip = (skip_cnt != SKIP_V);
  assign match   = (dut_data == mem[rd_ptr[AW-1:0]]);

  assign done = (state == ST_DONE);
  assign busy = (state == ST_ARMED);

  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (push || dut_valid) state_nxt = ST_ARMED;
      ST_ARMED: if (!dut_valid && idle_cnt == IDLE_LAST) state_nxt = ST_DONE;
      default:  state_nxt = state;
    endcase
  end

  // Symbol storage is data only; pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= golden_data;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      idle_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (golden_valid && full && live) overflow <= 1'b1;
      if (state == ST_ARMED) idle_cnt <= dut_valid ? '0 : idle_cnt + IW'(1);
    end
  end

  // Statistics update one cycle after the DUT symbol is presented.
  always_ff @(posedge clk) begin
    if (clr) begin
      err_count       <= '0;
      ok_count        <= '0;
      underflow_count <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      skip_cnt        <= '0;
    end else begin
      if (under) underflow_count <= sat_inc(underflow_count);
      if (pop) begin
        if (in_skip) begin
          skip_cnt <= skip_cnt + SW'(1);
        end else if (match) begin
          ok_count <= sat_inc(ok_count);
        end else begin
          err_count <= sat_inc(err_count);
          if (!first_err_valid) begin
            first_err_idx   <= sat_add(err_count, ok_count);
            first_err_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_phy_stream_checker.sv
// Directed bench for phy_stream_checker: three instances cover serial stream, SKIP and a shallow FIFO.
module tb_phy_stream_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int tests = 0;
  int failed = 0;

  // Instance A: W=1, DEPTH=64, TIMEOUT=200, SKIP=0
  logic        a_clear, a_gv, a_gd, a_gr, a_dv, a_dd, a_ovf, a_fev, a_done, a_busy;
  logic [31:0] a_err, a_ok, a_und, a_idx;
  // Instance B: W=4, SKIP=3
  logic        b_clear, b_gv, b_gr, b_dv, b_ovf, b_fev, b_done, b_busy;
  logic [3:0]  b_gd, b_dd;
  logic [31:0] b_err, b_ok, b_und, b_idx;
  // Instance C: W=4, DEPTH=4, CNT_W=3
  logic        c_clear, c_gv, c_gr, c_dv, c_ovf, c_fev, c_done, c_busy;
  logic [3:0]  c_gd, c_dd;
  logic [2:0]  c_err, c_ok, c_und, c_idx;

  phy_stream_checker #(.W(1), .DEPTH(64), .CNT_W(32), .TIMEOUT(200), .SKIP(0)) u_a (
    .clk(clk), .rst(rst), .clear(a_clear),
    .golden_data(a_gd), .golden_valid(a_gv), .golden_ready(a_gr),
    .dut_data(a_dd), .dut_valid(a_dv),
    .err_count(a_err), .ok_count(a_ok), .underflow_count(a_und), .overflow(a_ovf),
    .first_err_idx(a_idx), .first_err_valid(a_fev), .done(a_done), .busy(a_busy));

  phy_stream_checker #(.W(4), .DEPTH(16), .CNT_W(32), .TIMEOUT(50), .SKIP(3)) u_b (
    .clk(clk), .rst(rst), .clear(b_clear),
    .golden_data(b_gd), .golden_valid(b_gv), .golden_ready(b_gr),
    .dut_data(b_dd), .dut_valid(b_dv),
    .err_count(b_err), .ok_count(b_ok), .underflow_count(b_und), .overflow(b_ovf),
    .first_err_idx(b_idx), .first_err_valid(b_fev), .done(b_done), .busy(b_busy));

  phy_stream_checker #(.W(4), .DEPTH(4), .CNT_W(3), .TIMEOUT(50), .SKIP(0)) u_c (
    .clk(clk), .rst(rst), .clear(c_clear),
    .golden_data(c_gd), .golden_valid(c_gv), .golden_ready(c_gr),
    .dut_data(c_dd), .dut_valid(c_dv),
    .err_count(c_err), .ok_count(c_ok), .underflow_count(c_und), .overflow(c_ovf),
    .first_err_idx(c_idx), .first_err_valid(c_fev), .done(c_done), .busy(c_busy));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Serial run on A: 16 pushes of 1010..., then 16 DUT bits with optional inversions.
  task automatic a_run16(input logic [15:0] flip);
    for (int i = 0; i < 16; i++) begin
      a_gv = 1'b1; a_gd = (i % 2 == 0);
      @(negedge clk);
    end
    a_gv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_dv = 1'b1; a_dd = (i % 2 == 0) ^ flip[i];
      @(negedge clk);
    end
    a_dv = 1'b0;
  endtask

  task automatic a_pulse_clear();
    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
  endtask

  task automatic c_pulse_clear();
    c_clear = 1'b1;
    @(negedge clk);
    c_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_clear = 0; a_gv = 0; a_gd = 0; a_dv = 0; a_dd = 0;
    b_clear = 0; b_gv = 0; b_gd = 0; b_dv = 0; b_dd = 0;
    c_clear = 0; c_gv = 0; c_gd = 0; c_dv = 0; c_dd = 0;
    @(negedge clk);
    check("rst_ok", a_ok, 0);
    check("rst_err", a_err, 0);
    check("rst_gready", a_gr, 1);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_ovf", c_ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clean serial stream and exact timeout
    a_run16(16'h0000);
    check("a_ok16", a_ok, 16);
    check("a_err0", a_err, 0);
    check("a_fev0", a_fev, 0);
    check("a_busy", a_busy, 1);
    repeat (199) @(negedge clk);
    check("a_done_early", a_done, 0);
    @(negedge clk);
    check("a_done_200", a_done, 1);
    check("a_busy_done", a_busy, 0);

    // Inputs ignored once done
    a_gv = 1'b1; a_dv = 1'b1; a_dd = 1'b1;
    check("a_gready_done", a_gr, 0);
    @(negedge clk);
    a_gv = 1'b0; a_dv = 1'b0;
    check("a_ok_frozen", a_ok, 16);
    check("a_und_frozen", a_und, 0);

    a_pulse_clear();
    check("a_clr_done", a_done, 0);
    check("a_clr_ok", a_ok, 0);

    // Bits 5 and 11 inverted
    a_run16(16'h0820);
    check("a_err2", a_err, 2);
    check("a_ok14", a_ok, 14);
    check("a_idx5", a_idx, 5);
    check("a_fev1", a_fev, 1);

    // SKIP=3 on B
    for (int i = 0; i < 8; i++) begin
      b_gv = 1'b1; b_gd = 4'(i + 1);
      @(negedge clk);
    end
    b_gv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_dv = 1'b1; b_dd = (i < 3) ? 4'hF : 4'(i + 1);
      @(negedge clk);
    end
    b_dv = 1'b0;
    check("b_ok5", b_ok, 5);
    check("b_err0", b_err, 0);
    check("b_und0", b_und, 0);

    // DEPTH=4 overflow then drain into underflow
    for (int i = 0; i < 6; i++) begin
      c_gv = 1'b1; c_gd = 4'(i + 1);
      @(negedge clk);
    end
    c_gv = 1'b0;
    check("c_gready_full", c_gr, 0);
    check("c_ovf", c_ovf, 1);
    for (int i = 0; i < 6; i++) begin
      c_dv = 1'b1; c_dd = 4'(i + 1);
      @(negedge clk);
    end
    c_dv = 1'b0;
    check("c_ok4", c_ok, 4);
    check("c_und2", c_und, 2);
    check("c_err0", c_err, 0);

    // Underflow with simultaneous push: no bypass
    c_pulse_clear();
    check("c_clr_ovf", c_ovf, 0);
    c_gv = 1'b1; c_gd = 4'h5; c_dv = 1'b1; c_dd = 4'h5;
    @(negedge clk);
    c_gv = 1'b0; c_dv = 1'b0;
    check("c_und1", c_und, 1);
    check("c_ok_nobypass", c_ok, 0);
    c_dv = 1'b1; c_dd = 4'h5;
    @(negedge clk);
    c_dv = 1'b0;
    check("c_ok_after", c_ok, 1);

    // Push while full with simultaneous pop: push refused, bench holds valid
    c_pulse_clear();
    for (int i = 0; i < 4; i++) begin
      c_gv = 1'b1; c_gd = 4'(i + 1);
      @(negedge clk);
    end
    c_gd = 4'h9; c_dv = 1'b1; c_dd = 4'h1;
    check("c_gready_pp", c_gr, 0);
    @(negedge clk);
    c_dv = 1'b0;
    check("c_ovf_pp", c_ovf, 1);
    check("c_ok_pp", c_ok, 1);
    @(negedge clk);
    c_gv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_dv = 1'b1; c_dd = (i < 3) ? 4'(i + 2) : 4'h9;
      @(negedge clk);
    end
    c_dv = 1'b0;
    check("c_ok5", c_ok, 5);
    check("c_err_pp", c_err, 0);
    check("c_und_pp", c_und, 0);

    // 3-bit counter saturation
    c_pulse_clear();
    for (int i = 0; i <= 10; i++) begin
      c_gv = (i < 10); c_gd = 4'(i);
      c_dv = (i > 0);  c_dd = 4'(i - 1);
      @(negedge clk);
    end
    c_gv = 1'b0; c_dv = 1'b0;
    check("c_ok_sat", c_ok, 7);
    check("c_err_sat", c_err, 0);

    // Mid-run reset with a compare in the same cycle
    a_pulse_clear();
    for (int i = 0; i < 10; i++) begin
      a_gv = 1'b1; a_gd = (i % 2 == 0);
      @(negedge clk);
    end
    a_gv = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_dv = 1'b1; a_dd = (i % 2 == 0);
      @(negedge clk);
    end
    check("a_ok7", a_ok, 7);
    rst = 1'b1; a_dd = 1'b0;
    @(negedge clk);
    rst = 1'b0; a_dv = 1'b0;
    check("a_rst_ok", a_ok, 0);
    check("a_rst_busy", a_busy, 0);
    check("a_rst_gready", a_gr, 1);
    for (int i = 0; i < 3; i++) begin
      a_gv = 1'b1; a_gd = (i == 1);
      @(negedge clk);
    end
    a_gv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_dv = 1'b1; a_dd = (i == 1);
      @(negedge clk);
    end
    a_dv = 1'b0;
    check("a_ok3", a_ok, 3);
    for (int n = 0; n < 300 && !a_done; n++) @(negedge clk);
    check("a_done_run3", a_done, 1);
    a_pulse_clear();
    check("a_clr2_done", a_done, 0);
    check("a_clr2_ok", a_ok, 0);
    check("a_clr2_err", a_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
